// File: rtl/hps_reset_pulser_pkg.sv
// Shared types and helpers for the HPS reset-request pulser.
package hps_reset_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } ch_state_e;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  localparam int unsigned FLD_MAX = 512;

  typedef logic [FLD_MAX-1:0] fld_vec_t;

  function automatic logic [31:0] field_get(
    input fld_vec_t    vec,
    input int unsigned idx,
    input int unsigned w
  );
    fld_vec_t    sh;
    logic [31:0] mask;
    sh   = vec >> (idx * w);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/hps_reset_pulse_channel.sv
// One request channel: input stages, edge detect,
// pulse/holdoff FSM with its down-counter, sticky drop flag.
module hps_reset_pulse_channel
  import hps_reset_pulser_pkg::*;
#(
  parameter int               CNT_W       = 8,
  parameter logic [CNT_W-1:0] PULSE_LEN   = CNT_W'(6),
  parameter logic [CNT_W-1:0] HOLDOFF_LEN = CNT_W'(16),
  parameter logic             EDGE_TYPE   = EDGE_RISE,
  parameter logic             IGNORE_RST  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic clr_dropped_i,
  input  logic preempt_i,
  output logic trigger_o,
  output logic reset_o,
  output logic busy_o,
  output logic dropped_o
);

  localparam logic [CNT_W-1:0] LOAD_P =
    (PULSE_LEN == '0) ? '0 : PULSE_LEN - 1'b1;
  localparam logic [CNT_W-1:0] LOAD_H =
    (HOLDOFF_LEN == '0) ? '0 : HOLDOFF_LEN - 1'b1;
  localparam logic HOLD_EN = (HOLDOFF_LEN != '0);

  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_q;
  logic             s2_q;
  logic             reset_q;
  logic             busy_q;
  logic             dropped_q;
  logic             dropped_d;

  logic rise_w;
  logic fall_w;
  logic edge_w;
  logic idle_w;
  logic drop_set_w;
  logic keep_w;

  assign rise_w = s1_q & ~s2_q;
  assign fall_w = ~s1_q & s2_q;
  assign edge_w = (EDGE_TYPE == EDGE_FALL) ? fall_w : rise_w;
  assign idle_w = (state_q == ST_IDLE);

  assign trigger_o  = rst_ni & edge_w & idle_w & ~preempt_i;
  assign drop_set_w = rst_ni & edge_w & ~idle_w & ~preempt_i;
  assign dropped_d  = drop_set_w | (dropped_q & ~clr_dropped_i);

  // A pulse already in flight may outlive reset; holdoff never does.
  assign keep_w = IGNORE_RST & (state_q == ST_PULSE) & (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dropped_q <= 1'b0;
      if (keep_w) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        reset_q <= 1'b0;
        busy_q  <= 1'b0;
      end
    end else begin
      s1_q      <= req_i;
      s2_q      <= s1_q;
      dropped_q <= dropped_d;
      if (preempt_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        reset_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (trigger_o) begin
              state_q <= ST_PULSE;
              cnt_q   <= LOAD_P;
              reset_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (cnt_q == '0) begin
              reset_q <= 1'b0;
              if (HOLD_EN) begin
                state_q <= ST_HOLDOFF;
                cnt_q   <= LOAD_H;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_HOLDOFF: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            reset_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign reset_o   = reset_q;
  assign busy_o    = busy_q;
  assign dropped_o = dropped_q;

endmodule

// File: rtl/hps_reset_pulser.sv
// N-channel HPS reset-request pulse generator.
// Channel 0 is cold reset and may preempt all others.
module hps_reset_pulser
  import hps_reset_pulser_pkg::*;
#(
  parameter int                      NUM_CH       = 2,
  parameter int                      CNT_W        = 8,
  parameter logic [NUM_CH*CNT_W-1:0] PULSE_LEN    = {8'd2, 8'd6},
  parameter logic [NUM_CH*CNT_W-1:0] HOLDOFF_LEN  = {8'd4, 8'd16},
  parameter logic [NUM_CH-1:0]       EDGE_TYPE    = 2'b11,
  parameter logic [NUM_CH-1:0]       IGNORE_RST_WHILE_BUSY = 2'b11,
  parameter logic                    COLD_PREEMPT = 1'b1
) (
  input  logic              clock_clk,
  input  logic              hps_fpga_reset_n,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              clr_dropped,
  output logic [NUM_CH-1:0] reset_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] dropped
);

  logic              cold_trig;
  logic              cold_pre;
  logic [NUM_CH-1:0] trig_unused;

  assign cold_pre = COLD_PREEMPT & cold_trig;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] PL = CNT_W'(
      field_get(fld_vec_t'(PULSE_LEN), i, CNT_W));
    localparam logic [CNT_W-1:0] HL = CNT_W'(
      field_get(fld_vec_t'(HOLDOFF_LEN), i, CNT_W));

    logic pre;
    logic trig;

    if (i == 0) begin : g_cold
      assign pre = 1'b0;
    end else begin : g_warm
      assign pre = cold_pre;
    end

    hps_reset_pulse_channel #(
      .CNT_W      (CNT_W),
      .PULSE_LEN  (PL),
      .HOLDOFF_LEN(HL),
      .EDGE_TYPE  (EDGE_TYPE[i]),
      .IGNORE_RST (IGNORE_RST_WHILE_BUSY[i])
    ) u_ch (
      .clk_i        (clock_clk),
      .rst_ni       (hps_fpga_reset_n),
      .req_i        (req_in[i]),
      .clr_dropped_i(clr_dropped),
      .preempt_i    (pre),
      .trigger_o    (trig),
      .reset_o      (reset_out[i]),
      .busy_o       (busy[i]),
      .dropped_o    (dropped[i])
    );

    assign trig_unused[i] = trig;
  end

  assign cold_trig = g_ch[0].trig;

endmodule
